// File: rtl/runner_packer_pkg.sv
// runner_packer shared helpers: ratio/clog2 and FIFO entry layout.
// Optional parity field enabled by RUNNER_PACKER_PARITY_EN.
package runner_packer_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int ratio(input int win, input int wout);
    return wout / win;
  endfunction

  localparam int LAST_W = 1;
`ifdef RUNNER_PACKER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Entry = {parity?, last, data}, data in the LSBs
  function automatic int entry_width(input int wout);
    return wout + LAST_W + PAR_W;
  endfunction

endpackage

// File: rtl/runner_packer_if.sv
// Stream bundle for runner_packer: narrow input beats, wide output words.
// out_parity exists only with RUNNER_PACKER_PARITY_EN.
interface runner_packer_if #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_IN-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] out_data;
  logic                 out_last;
  logic [CNT_WIDTH-1:0] word_count;
`ifdef RUNNER_PACKER_PARITY_EN
  logic                 out_parity;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output word_count, out_parity
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  word_count, out_parity
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output word_count
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  word_count
  );
`endif
endinterface

// File: rtl/runner_packer_fifo.sv
// First-word-fall-through sync FIFO; extra pointer MSB tells full from empty.
// Head is read straight from the register array.
module runner_packer_fifo
  import runner_packer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ENTRY_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ENTRY_WIDTH-1:0] wdata,
  output logic [ENTRY_WIDTH-1:0] rdata,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/runner_packer.sv
// Packs WIDTH_IN beats little-endian into WIDTH_OUT words behind a FIFO.
// Define RUNNER_PACKER_PARITY_EN to add out_parity.
module runner_packer
  import runner_packer_pkg::*;
#(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  runner_packer_if.slave bus
);
  localparam int RATIO = ratio(WIDTH_IN, WIDTH_OUT);
  localparam int KW    = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
  localparam int EW    = entry_width(WIDTH_OUT);

  logic [KW-1:0]        k_q, k_d;
  logic [WIDTH_OUT-1:0] asm_q, asm_d;
  logic [WIDTH_OUT-1:0] beat, word;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [EW-1:0]        wdata, rdata;
  logic full, empty, head_ok;
  logic in_fire, out_fire, done;

  assign head_ok  = !empty && !reset;
  assign in_fire  = bus.in_valid && !full;
  assign out_fire = head_ok && bus.out_ready;
  assign done     = in_fire &&
                    (bus.in_last || k_q == KW'(RATIO - 1));

  always_comb begin
    beat = '0;
    beat[WIDTH_IN-1:0] = bus.in_data;
    word  = asm_q | (beat << (int'(k_q) * WIDTH_IN));
    asm_d = asm_q;
    k_d   = k_q;
    cnt_d = cnt_q + CNT_WIDTH'(out_fire);
    if (done) begin
      asm_d = '0;
      k_d   = '0;
    end else if (in_fire) begin
      asm_d = word;
      k_d   = k_q + KW'(1);
    end
  end

`ifdef RUNNER_PACKER_PARITY_EN
  assign wdata = {^word, bus.in_last, word};
  assign bus.out_parity = head_ok & rdata[WIDTH_OUT+1];
`else
  assign wdata = {bus.in_last, word};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q   <= '0;
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      k_q   <= k_d;
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  runner_packer_fifo #(
    .DEPTH      (DEPTH),
    .ENTRY_WIDTH(EW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (done),
    .pop  (out_fire),
    .wdata(wdata),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );

  // in_ready comes from FIFO pointers only, never from out_ready
  assign bus.in_ready   = !full;
  assign bus.out_valid  = head_ok;
  assign bus.out_data   = head_ok ? rdata[WIDTH_OUT-1:0] : '0;
  assign bus.out_last   = head_ok & rdata[WIDTH_OUT];
  assign bus.word_count = cnt_q;

endmodule

// File: tb/tb_runner_packer.sv
// Randomised + directed bench for runner_packer against a queue model.
// Parity checks follow RUNNER_PACKER_PARITY_EN.
module tb_runner_packer;
  localparam int WI = 4;
  localparam int WO = 8;
  localparam int DEPTH = 4;
  localparam int CW = 16;
  localparam int RATIO = WO / WI;

  typedef struct {
    logic [WO-1:0] d;
    bit            l;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  runner_packer_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .CNT_WIDTH(CW)) bus ();

  runner_packer #(
    .WIDTH_IN(WI), .WIDTH_OUT(WO), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t mq[$];
  int   beats[$];
  int   cnt = 0;
  bit   rst_now = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit parity8(input logic [WO-1:0] w);
    int n = 0;
    for (int i = 0; i < WO; i++) n += int'(w[i]);
    return bit'(n % 2);
  endfunction

  task automatic compare();
    bit v;
    v = !rst_now && mq.size() > 0;
    chk("in_ready", longint'(bus.in_ready), longint'(mq.size() < DEPTH));
    chk("out_valid", longint'(bus.out_valid), longint'(v));
    chk("out_data", longint'(bus.out_data), v ? longint'(mq[0].d) : 0);
    chk("out_last", longint'(bus.out_last), v ? longint'(mq[0].l) : 0);
    chk("word_count", longint'(bus.word_count), longint'(cnt % 65536));
`ifdef RUNNER_PACKER_PARITY_EN
    chk("out_parity", longint'(bus.out_parity), v ? longint'(parity8(mq[0].d)) : 0);
`endif
  endtask

  task automatic step(input bit iv, input int id, input bit il,
                      input bit ordy, input bit rst);
    bit   ifire, ofire;
    ent_t e;
    int   w;
    bus.in_valid  = iv;
    bus.in_data   = WI'(id);
    bus.in_last   = il;
    bus.out_ready = ordy;
    reset = rst;
    rst_now = rst;
    if (rst) begin
      mq.delete();
      beats.delete();
      cnt = 0;
    end else begin
      ifire = iv && mq.size() < DEPTH;
      ofire = ordy && mq.size() > 0;
      if (ofire) begin
        void'(mq.pop_front());
        cnt++;
      end
      if (ifire) begin
        beats.push_back(id % 16);
        if (beats.size() == RATIO || il) begin
          w = 0;
          foreach (beats[i]) w = w | (beats[i] << (WI * i));
          e.d = WO'(w);
          e.l = il;
          mq.push_back(e);
          beats.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_last = 0;
    bus.out_ready = 0;
    reset = 1;
    #1;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_word_count", longint'(bus.word_count), 0);

    step(1, 'h3, 0, 1, 0);
    step(1, 'hA, 0, 1, 0);
    chk("pack_data", longint'(bus.out_data), 'hA3);
    chk("pack_last", longint'(bus.out_last), 0);
`ifdef RUNNER_PACKER_PARITY_EN
    chk("par_a3", longint'(bus.out_parity), 0);
`endif
    step(0, 0, 0, 1, 0);
    chk("pack_count", longint'(bus.word_count), 1);

    step(1, 'h5, 1, 1, 0);
    chk("early_data", longint'(bus.out_data), 'h05);
    chk("early_last", longint'(bus.out_last), 1);
    step(0, 0, 0, 1, 0);

`ifdef RUNNER_PACKER_PARITY_EN
    step(1, 'h2, 0, 0, 0);
    step(1, 'hA, 0, 0, 0);
    chk("par_a2", longint'(bus.out_parity), 1);
    step(0, 0, 0, 1, 0);
`endif

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0);
    chk("bp_in_ready", longint'(bus.in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_pop", longint'(bus.out_data), longint'(((2*i+1) << 4) | (2*i)));
      step(0, 0, 0, 1, 0);
    end
    step(1, 8, 0, 0, 0);
    step(1, 9, 0, 0, 0);
    chk("bp_98", longint'(bus.out_data), 'h98);
    step(0, 0, 0, 1, 0);
    chk("bp_count", longint'(bus.word_count), 5);

    step(1, 'h7, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 'h1, 0, 0, 0);
    step(1, 'h2, 0, 0, 0);
    chk("rmid_data", longint'(bus.out_data), 'h21);
    step(0, 0, 0, 1, 0);
    chk("rmid_empty", longint'(bus.out_valid), 0);

    for (int n = 0; n < 3000; n++) begin
      step(bit'($urandom_range(3) != 0),
           int'($urandom_range(15)),
           bit'($urandom_range(3) == 0),
           bit'($urandom_range(2) != 0),
           bit'($urandom_range(99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/runner_packer.md
# runner_packer

Parametrised successor to the runner test top. It is a streaming width converter for cocotb runner regression designs. It packs narrow input beats into wide output words, buffers them in a small FIFO, and presents them on a valid/ready interface. The block supplies real handshake, counter and buffering behaviour that runner tests can build, parametrise and drive across simulators.

## Interface
Parameters:
- WIDTH_IN, default 4: input beat width in bits; must be ≥1.
- WIDTH_OUT, default 8: output word width in bits; must be an integer multiple of WIDTH_IN.
- DEPTH, default 4: FIFO depth in output words; must be a power of two, ≥2.
- CNT_WIDTH, default 16: width of the popped-word counter.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: sole clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, WIDTH_IN: input beat.
- in_last, input, 1: closes the current word early; the remaining slices are zero-padded.
- out_valid, output, 1: output word available.
- out_ready, input, 1: consumer accepts the word.
- out_data, output, WIDTH_OUT: head word; 0 when out_valid is 0.
- out_last, output, 1: head word was closed by in_last; 0 when out_valid is 0.
- word_count, output, CNT_WIDTH: number of words popped since reset; wraps modulo 2^CNT_WIDTH.

## Operation
- RATIO = WIDTH_OUT/WIDTH_IN. A slice index k runs 0..RATIO-1.
- Input fire = in_valid && in_ready. On fire, in_data is written to bits [k*WIDTH_IN +: WIDTH_IN] of the assembly register. Packing is little-endian: the first beat lands in the LSBs.
- The word completes when k==RATIO-1 or in_last=1 on the fire. On completion:
  - the word is pushed to the FIFO;
  - unfilled slices are 0;
  - the last flag is stored alongside the word;
  - k returns to 0 and the assembly register clears.
- Otherwise k increments.
- in_ready = !fifo_full. It is registered-state only, with no combinational path from out_ready.
- Output fire = out_valid && out_ready. It pops the head and increments word_count.
- Push and pop in the same cycle: both take effect and the occupancy is unchanged.
- When full, in_ready=0, so no push can occur. A pop while full raises in_ready on the next cycle.
- Empty: out_valid=0. out_data and out_last are forced to 0.
- RATIO==1: every beat is a complete word; in_last only sets out_last.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, word_count=0, k=0, FIFO empty.
- Reset mid-operation discards the partial word and all buffered words. No output fire is counted in the reset cycle.
- Latency: completing beat fire at edge N gives out_valid=1 and out_data valid after edge N, visible in cycle N+1.
- The FIFO is first-word fall-through; the head is presented from registered state.
- Throughput: one input beat per cycle and one output word per cycle while not full.
- out_data and out_last are held stable while out_valid=1 and out_ready=0.

## Configuration
- RUNNER_PACKER_PARITY_EN defined:
  - adds output port out_parity (1 bit) = even parity (XOR reduction) of out_data;
  - stored per word in the FIFO;
  - 0 when out_valid=0 or in reset.
- RUNNER_PACKER_PARITY_EN not defined: port absent, no parity storage. All other behaviour is identical.

## Structure
- Package runner_packer_pkg holds:
  - RATIO derivation helper and clog2 function;
  - the FIFO entry layout (data, last, optional parity) as field-width constants.
- Sub-module runner_packer_fifo:
  - synchronous FIFO with parameters DEPTH and ENTRY_WIDTH;
  - ports: clk, reset, push, pop, wdata, rdata, full, empty;
  - pointers of clog2(DEPTH)+1 bits for full/empty disambiguation.
- The top holds the slice index, the assembly register and word_count.

## Test plan
All scenarios use WIDTH_IN=4, WIDTH_OUT=8, DEPTH=4, CNT_WIDTH=16.
- Reset: assert reset 2 cycles -> in_ready=1, out_valid=0, out_data=0x00, word_count=0.
- Pack: beats 0x3 then 0xA, out_ready=1 -> one cycle later out_data=0xA3, out_last=0; word_count=1 after the pop.
- Early close: single beat 0x5 with in_last=1 -> out_data=0x05, out_last=1.
- Backpressure: out_ready=0, stream 10 beats 0x0..0x9:
  - in_ready falls after 8 beats (4 words);
  - out_ready=1 then pops 0x10, 0x32, 0x54, 0x76 in order;
  - beats 0x8/0x9 then yield 0x98;
  - word_count=5.
- Reset mid-word: beat 0x7 accepted, reset 1 cycle, then beats 0x1, 0x2 -> out_data=0x21. No 0x?7 word ever appears.
- Parity (macro defined): word 0xA3 -> out_parity=0; word 0xA2 -> out_parity=1.
